// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC/nPC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_TA   = 2'b01;
  localparam logic [1:0] PC_SEL_ALU  = 2'b10;
  localparam logic [1:0] PC_SEL_TRAP = 2'b11;

  localparam int unsigned DEF_INSTR_BYTES = 4;

endpackage

// File: rtl/pc_npc_pair.sv
// PC/nPC register pair with load enable and a 4-way nPC source mux.
module pc_npc_pair
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             le,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] ta,
  input  logic [WIDTH-1:0] alu,
  input  logic [WIDTH-1:0] trap_vec,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc
);

  localparam logic [WIDTH-1:0] Step      = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] AlignMask = ~WIDTH'(3);

  logic [WIDTH-1:0] pc_q, npc_q, pc_d, npc_d, trap_al;

  always_comb begin
    trap_al = trap_vec & AlignMask;
    pc_d    = npc_q;
    npc_d   = npc_q + Step;
    case (sel)
      PC_SEL_TA:   npc_d = ta & AlignMask;
      PC_SEL_ALU:  npc_d = alu & AlignMask;
      // Traps have no delay slot: both registers jump to the vector.
      PC_SEL_TRAP: begin
        pc_d  = trap_al;
        npc_d = trap_al + Step;
      end
      default:     npc_d = npc_q + Step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      pc_q  <= RESET_PC;
      npc_q <= RESET_PC + Step;
    end else if (le) begin
      pc_q  <= pc_d;
      npc_q <= npc_d;
    end
  end

  assign pc  = pc_q;
  assign npc = npc_q;

endmodule

// File: rtl/pc_sequencer.sv
// SPARC fetch sequencer: picks the next-nPC source, handles delayed branches and annulment.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             stall,
  input  logic             br_taken,
  input  logic             br_uncond,
  input  logic             br_annul,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] ta,
  input  logic             jmpl_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             trap_req,
  input  logic [WIDTH-1:0] trap_vec,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             pc_le,
  output logic [1:0]       pc_mux_sel,
  output logic             squash,
  output logic             fetch_valid,
  output logic             misalign
);

  state_e     state_q;
  logic       pc_le_q, squash_q, fetch_valid_q, misalign_q;
  logic [1:0] sel_q;

  logic       upd, br_live, annul_d, target_mis;
  logic [1:0] sel_d;

  always_comb begin
    upd        = (state_q != StBoot) && (!stall || trap_req);
    // A branch sitting in an annulled slot is not executed.
    br_live    = br_valid && !squash_q;
    sel_d      = PC_SEL_SEQ;
    target_mis = 1'b0;
    annul_d    = 1'b0;
    if (trap_req) begin
      sel_d      = PC_SEL_TRAP;
      target_mis = |trap_vec[1:0];
    end else if (jmpl_valid) begin
      sel_d      = PC_SEL_ALU;
      target_mis = |alu_out[1:0];
    end else begin
      if (br_live && br_taken) begin
        sel_d      = PC_SEL_TA;
        target_mis = |ta[1:0];
      end
      annul_d = br_live && br_annul && (!br_taken || br_uncond);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q       <= StBoot;
      pc_le_q       <= 1'b0;
      sel_q         <= PC_SEL_SEQ;
      squash_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_le_q    <= upd;
      misalign_q <= upd && target_mis;
      if (upd) begin
        sel_q    <= sel_d;
        squash_q <= annul_d;
      end
      case (state_q)
        StBoot: begin
          state_q       <= StRun;
          fetch_valid_q <= 1'b1;
        end
        StRun, StHold: state_q <= (stall && !trap_req) ? StHold : StRun;
        default: begin
          state_q       <= StBoot;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  pc_npc_pair #(
    .WIDTH       (WIDTH),
    .RESET_PC    (RESET_PC),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pair (
    .clk      (clk),
    .clr      (clr),
    .le       (upd),
    .sel      (sel_d),
    .ta       (ta),
    .alu      (alu_out),
    .trap_vec (trap_vec),
    .pc       (pc),
    .npc      (npc)
  );

  assign pc_le       = pc_le_q;
  assign pc_mux_sel  = sel_q;
  assign squash      = squash_q;
  assign fetch_valid = fetch_valid_q;
  assign misalign    = misalign_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Sequencing controller for the SPARC fetch path. It owns the PC/nPC pair and picks the next-nPC source each cycle: sequential (nPC+4), branch target (TA), jump/return target (ALU_OUT) or trap vector. It implements delayed-branch semantics, including annulment of the delay slot. It sits between decode/branch-resolution logic and the instruction memory address port, and drives the shared PC-source mux select.

Parameters:
WIDTH, 32, address width in bits
RESET_PC, 0, PC value loaded on reset (nPC loads RESET_PC+4)
INSTR_BYTES, 4, sequential increment

Ports:
clk  in  1  clock; all state updates on rising edge
clr  in  1  reset, synchronous, active-low; sampled on rising clk edge
stall  in  1  hold PC/nPC this cycle (hazard/memory wait)
br_taken  in  1  conditional or unconditional branch resolved taken this cycle
br_uncond  in  1  branch is BA/BN class (annul rule differs)
br_annul  in  1  annul bit (a) of the resolving branch
br_valid  in  1  a branch resolves this cycle
ta  in  WIDTH  branch target address
jmpl_valid  in  1  JMPL/RETT resolves this cycle
alu_out  in  WIDTH  JMPL target
trap_req  in  1  trap taken this cycle
trap_vec  in  WIDTH  trap vector address
pc  out  WIDTH  current fetch address
npc  out  WIDTH  next PC
pc_le  out  1  PC/nPC advanced this cycle (registered)
pc_mux_sel  out  2  source loaded into nPC last update: 00 seq, 01 TA, 10 ALU, 11 trap
squash  out  1  instruction at pc is annulled (do not commit)
fetch_valid  out  1  pc holds a real fetch address
misalign  out  1  one-cycle pulse: selected target had nonzero low 2 bits

Behaviour:
- Reset (clr==0 at posedge): pc=RESET_PC, npc=RESET_PC+4, pc_le=0, pc_mux_sel=00, squash=0, fetch_valid=0, misalign=0, state=BOOT. Overrides every other input, including a reset asserted mid-stall or mid-branch.
- FSM states:
  - BOOT: one cycle, no PC/nPC update, fetch_valid=0; goes to RUN.
  - RUN: fetch_valid=1; PC/nPC updates follow the rules below.
  - HOLD: entered when stall=1 in RUN; pc/npc/squash frozen, pc_le=0; returns to RUN on the first cycle with stall=0, with no lost update.
- Update in RUN with stall=0, priority trap > jmpl > branch > sequential:
  - trap_req: pc<=trap_vec, npc<=trap_vec+4, sel=11, squash<=0. No delay slot.
  - jmpl_valid: pc<=npc, npc<=alu_out, sel=10.
  - br_valid & br_taken: pc<=npc, npc<=ta, sel=01.
  - otherwise: pc<=npc, npc<=npc+INSTR_BYTES, sel=00.
- Annulment: squash<=1 for exactly the next update when br_valid & br_annul & (!br_taken | br_uncond). Otherwise squash<=0 on each update.
- Annulled BA (br_uncond & br_annul & br_taken): the branch still redirects npc to ta; the delay slot is squashed.
- A branch whose own squash=1 is ignored: treat as sequential, no redirect, no annul.
- stall=1 with trap_req=1: the trap wins; the update is taken in that cycle.
- pc_le=1 in every cycle where pc/npc update, 0 otherwise.
- Arithmetic is modulo 2^WIDTH: npc=0xFFFFFFFC advances to 0x00000000 with no flag.
- Misaligned ta/alu_out/trap_vec: low 2 bits forced to 0 on load, and misalign pulses high for one cycle.
- Latency: input sampled at edge N; new pc visible after edge N.

Decomposition:
- Package pc_seq_pkg holds:
  - state encoding: BOOT, RUN, HOLD
  - PC_SEL_SEQ/TA/ALU/TRAP 2-bit constants
  - INSTR_BYTES default
- One sub-module: pc_npc_pair, the PC/nPC register pair with load-enable and a 4-way nPC source mux, controlled by this sequencer.

Test Plan:
- Reset then release with RESET_PC=0 -> BOOT cycle (fetch_valid=0), then pc=0,4,8,12 on successive edges, sel=00.
- At pc=8,npc=12: br_valid=1, taken=1, ta=0x100, annul=0 -> pc=12,npc=0x100 (sel=01); next pc=0x100,npc=0x104; squash stays 0.
- At pc=8: br_valid=1, taken=0, annul=1 -> pc=12 with squash=1; next cycle pc=16, squash=0.
- Stall held 3 cycles at pc=0x20 -> pc/npc frozen, pc_le=0; on release pc=0x24. Then trap_req with stall=1, trap_vec=0x800 -> pc=0x800, npc=0x804, sel=11.
- jmpl_valid with alu_out=0x1002 -> npc=0x1000, misalign pulses one cycle. Separately, npc=0xFFFFFFFC sequential step -> npc=0.
- clr=0 mid-branch (br_valid and stall both high) -> next edge pc=RESET_PC, squash=0, state BOOT.
